// File: rtl/fpu_interco_pkg.sv
// Shared types and sizing helpers for the FPU interconnect issue path.
package fpu_interco_pkg;

    localparam int DEF_DATA_WIDTH       = 32;
    localparam int DEF_NB_CORES         = 9;
    localparam int DEF_NB_APU_ARGS      = 3;
    localparam int DEF_APU_OPCODE_WIDTH = 6;
    localparam int DEF_FLAG_WIDTH       = 8;

    // Request as it travels from the arbitration tree to the FPU (default widths).
    typedef struct packed {
        logic [DEF_NB_APU_ARGS*DEF_DATA_WIDTH-1:0] operands;
        logic [DEF_APU_OPCODE_WIDTH-1:0]           op;
        logic [DEF_FLAG_WIDTH-1:0]                 flag;
        logic [DEF_NB_CORES-1:0]                   id;
    } fpu_req_t;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to address n entries (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head and
// modulo-DEPTH pointers, so non-power-of-two depths are supported.
module fpu_issue_fifo
    import fpu_interco_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_reg == '0);
    assign full    = (cnt_reg == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_reg[rd_ptr_reg];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage: each entry captures write data when the write pointer selects it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                mem_reg[gi] <= wdata;
            end
        end
    end

    // Pointer and fill-count bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue_stage.sv
// Request buffer and in-order response tracker in front of the shared FPU.
// Optional zero-latency path around the request FIFO: FPU_ISSUE_BYPASS_EN.
module fpu_issue_stage
    import fpu_interco_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int NB_CORES         = 9,
    parameter int ID_WIDTH         = NB_CORES,
    parameter int NB_APU_ARGS      = 3,
    parameter int APU_OPCODE_WIDTH = 6,
    parameter int FLAG_WIDTH       = 8,
    parameter int RFLAG_WIDTH      = 5,
    parameter int DEPTH            = 2,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              data_req_i,
    input  logic [NB_APU_ARGS*DATA_WIDTH-1:0] data_operands_i,
    input  logic [APU_OPCODE_WIDTH-1:0]       data_op_i,
    input  logic [ID_WIDTH-1:0]               data_ID_i,
    input  logic [FLAG_WIDTH-1:0]             data_flag_i,
    output logic                              data_gnt_o,
    output logic                              apu_req_o,
    output logic [NB_APU_ARGS*DATA_WIDTH-1:0] apu_operands_o,
    output logic [APU_OPCODE_WIDTH-1:0]       apu_op_o,
    output logic [FLAG_WIDTH-1:0]             apu_flag_o,
    input  logic                              apu_gnt_i,
    input  logic                              apu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]             apu_result_i,
    input  logic [RFLAG_WIDTH-1:0]            apu_rflags_i,
    output logic [NB_CORES-1:0]               data_r_valid_o,
    output logic [DATA_WIDTH-1:0]             data_r_data_o,
    output logic [RFLAG_WIDTH-1:0]            data_r_flags_o,
    output logic                              err_o
);

    localparam int OUT_W = cnt_width(MAX_OUTSTANDING);

    typedef struct packed {
        logic [NB_APU_ARGS*DATA_WIDTH-1:0] operands;
        logic [APU_OPCODE_WIDTH-1:0]       op;
        logic [FLAG_WIDTH-1:0]             flag;
        logic [ID_WIDTH-1:0]               id;
    } req_t;

    req_t              in_req;
    req_t              head_req;
    req_t              issue_req;
    logic              req_empty;
    logic              req_full;
    logic              req_push;
    logic              req_pop;
    logic              trk_empty;
    logic              trk_full;
    logic              trk_pop;
    logic [ID_WIDTH-1:0] trk_id;
    logic [OUT_W-1:0]  out_reg;
    logic              can_issue;
    logic              issue;
    logic              bypass;

    // Pack the upstream request fields.
    always_comb begin
        in_req.operands = data_operands_i;
        in_req.op       = data_op_i;
        in_req.flag     = data_flag_i;
        in_req.id       = data_ID_i;
    end

    // The counter is a register, so a same-cycle result never unblocks issue.
    assign can_issue = (out_reg < OUT_W'(MAX_OUTSTANDING)) && !trk_full;

`ifdef FPU_ISSUE_BYPASS_EN
    assign bypass     = req_empty && can_issue && data_req_i;
    assign issue_req  = bypass ? in_req : head_req;
    assign apu_req_o  = (!req_empty && can_issue) || bypass;
    assign data_gnt_o = !req_full || (bypass && apu_gnt_i);
    assign req_push   = data_req_i && data_gnt_o && !(bypass && apu_gnt_i);
`else
    assign bypass     = 1'b0;
    assign issue_req  = head_req;
    assign apu_req_o  = !req_empty && can_issue;
    assign data_gnt_o = !req_full;
    assign req_push   = data_req_i && data_gnt_o;
`endif

    assign issue          = apu_req_o && apu_gnt_i;
    assign req_pop        = issue && !bypass;
    assign trk_pop        = apu_rvalid_i && !trk_empty;
    assign apu_operands_o = issue_req.operands;
    assign apu_op_o       = issue_req.op;
    assign apu_flag_o     = issue_req.flag;

    fpu_issue_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_push),
        .wdata (in_req),
        .pop   (req_pop),
        .rdata (head_req),
        .empty (req_empty),
        .full  (req_full)
    );

    fpu_issue_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_tracker (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .wdata (issue_req.id),
        .pop   (trk_pop),
        .rdata (trk_id),
        .empty (trk_empty),
        .full  (trk_full)
    );

    // Outstanding-operation counter: issue and retire in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
        end else begin
            case ({issue, trk_pop})
                2'b10:   out_reg <= out_reg + 1'b1;
                2'b01:   out_reg <= out_reg - 1'b1;
                default: out_reg <= out_reg;
            endcase
        end
    end

    // Result routing back to the originating core, plus sticky orphan-result flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r_valid_o <= '0;
            data_r_data_o  <= '0;
            data_r_flags_o <= '0;
            err_o          <= 1'b0;
        end else begin
            data_r_valid_o <= trk_pop ? NB_CORES'(trk_id) : '0;
            if (trk_pop) begin
                data_r_data_o  <= apu_result_i;
                data_r_flags_o <= apu_rflags_i;
            end
            if (apu_rvalid_i && trk_empty) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Directed testbench for fpu_issue_stage (default build, DEPTH=2, MAX_OUTSTANDING=4).
module tb_fpu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req_i;
    logic [95:0] data_operands_i;
    logic [5:0]  data_op_i;
    logic [8:0]  data_ID_i;
    logic [7:0]  data_flag_i;
    logic        data_gnt_o;
    logic        apu_req_o;
    logic [95:0] apu_operands_o;
    logic [5:0]  apu_op_o;
    logic [7:0]  apu_flag_o;
    logic        apu_gnt_i;
    logic        apu_rvalid_i;
    logic [31:0] apu_result_i;
    logic [4:0]  apu_rflags_i;
    logic [8:0]  data_r_valid_o;
    logic [31:0] data_r_data_o;
    logic [4:0]  data_r_flags_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpu_issue_stage dut (
        .clk             (clk),
        .rst             (rst),
        .data_req_i      (data_req_i),
        .data_operands_i (data_operands_i),
        .data_op_i       (data_op_i),
        .data_ID_i       (data_ID_i),
        .data_flag_i     (data_flag_i),
        .data_gnt_o      (data_gnt_o),
        .apu_req_o       (apu_req_o),
        .apu_operands_o  (apu_operands_o),
        .apu_op_o        (apu_op_o),
        .apu_flag_o      (apu_flag_o),
        .apu_gnt_i       (apu_gnt_i),
        .apu_rvalid_i    (apu_rvalid_i),
        .apu_result_i    (apu_result_i),
        .apu_rflags_i    (apu_rflags_i),
        .data_r_valid_o  (data_r_valid_o),
        .data_r_data_o   (data_r_data_o),
        .data_r_flags_o  (data_r_flags_o),
        .err_o           (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        data_req_i = 1'b0;
        data_operands_i = '0;
        data_op_i = '0;
        data_ID_i = '0;
        data_flag_i = '0;
        apu_gnt_i = 1'b0;
        apu_rvalid_i = 1'b0;
        apu_result_i = '0;
        apu_rflags_i = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_gnt", data_gnt_o, 1);
        chk("rst_req", apu_req_o, 0);
        chk("rst_rvalid", data_r_valid_o, 0);
        chk("rst_err", err_o, 0);

        // Single request, immediate grant, result three cycles later.
        data_req_i = 1'b1;
        data_ID_i = 9'h004;
        data_op_i = 6'h15;
        data_flag_i = 8'hA5;
        data_operands_i = {32'h4000_0000, 32'h3F80_0000, 32'hDEAD_BEEF};
        apu_gnt_i = 1'b1;
        #1;
        chk("t1_gnt", data_gnt_o, 1);
        chk("t1_no_req_yet", apu_req_o, 0);
        step();
        data_req_i = 1'b0;
        #1;
        chk("t1_req", apu_req_o, 1);
        chk("t1_op", apu_op_o, 6'h15);
        chk("t1_flag", apu_flag_o, 8'hA5);
        chk("t1_opnd0", apu_operands_o[31:0], 32'hDEAD_BEEF);
        step();
        chk("t1_req_done", apu_req_o, 0);
        step();
        step();
        apu_rvalid_i = 1'b1;
        apu_result_i = 32'h3F80_0000;
        apu_rflags_i = 5'h01;
        step();
        apu_rvalid_i = 1'b0;
        #1;
        chk("t1_rvalid", data_r_valid_o, 9'h004);
        chk("t1_rdata", data_r_data_o, 32'h3F80_0000);
        chk("t1_rflags", data_r_flags_o, 5'h01);
        step();
        chk("t1_pulse_end", data_r_valid_o, 0);

        // FIFO fill with FPU stalled: two accepted, third waits for a pop.
        apu_gnt_i = 1'b0;
        data_req_i = 1'b1;
        data_ID_i = 9'h001;
        #1;
        chk("t2_gnt1", data_gnt_o, 1);
        step();
        data_ID_i = 9'h002;
        #1;
        chk("t2_gnt2", data_gnt_o, 1);
        step();
        data_ID_i = 9'h008;
        #1;
        chk("t2_gnt_full", data_gnt_o, 0);
        chk("t2_req", apu_req_o, 1);
        step();
        apu_gnt_i = 1'b1;
        #1;
        chk("t2_gnt_nocomb", data_gnt_o, 0);
        step();
        apu_gnt_i = 1'b0;
        #1;
        chk("t2_gnt_resume", data_gnt_o, 1);
        step();
        data_req_i = 1'b0;
        apu_gnt_i = 1'b1;
        step();
        step();
        #1;
        chk("t2_drained", apu_req_o, 0);
        apu_rvalid_i = 1'b1;
        apu_result_i = 32'h0000_0011;
        step();
        chk("t2_r1", data_r_valid_o, 9'h001);
        step();
        chk("t2_r2", data_r_valid_o, 9'h002);
        step();
        apu_rvalid_i = 1'b0;
        chk("t2_r3", data_r_valid_o, 9'h008);
        chk("t2_err_clean", err_o, 0);

        // Outstanding limit: five back-to-back requests with interleaved IDs.
        apu_gnt_i = 1'b1;
        data_req_i = 1'b1;
        data_ID_i = 9'h001;
        step();
        data_ID_i = 9'h100;
        step();
        data_ID_i = 9'h010;
        step();
        data_ID_i = 9'h002;
        step();
        data_ID_i = 9'h020;
        step();
        data_req_i = 1'b0;
        #1;
        chk("t3_limit_req", apu_req_o, 0);
        chk("t3_limit_gnt", data_gnt_o, 1);
        step();
        chk("t3_still_block", apu_req_o, 0);
        apu_rvalid_i = 1'b1;
        #1;
        chk("t3_same_cyc", apu_req_o, 0);
        step();
        apu_rvalid_i = 1'b0;
        #1;
        chk("t3_resume", apu_req_o, 1);
        chk("t3_r1", data_r_valid_o, 9'h001);
        step();
        chk("t3_block_again", apu_req_o, 0);
        apu_rvalid_i = 1'b1;
        step();
        chk("t3_r2", data_r_valid_o, 9'h100);
        step();
        chk("t3_r3", data_r_valid_o, 9'h010);
        step();
        chk("t3_r4", data_r_valid_o, 9'h002);
        step();
        apu_rvalid_i = 1'b0;
        chk("t3_r5", data_r_valid_o, 9'h020);

        // Orphan result: nothing outstanding.
        apu_rvalid_i = 1'b1;
        step();
        apu_rvalid_i = 1'b0;
        #1;
        chk("t4_no_valid", data_r_valid_o, 0);
        chk("t4_err", err_o, 1);
        step();
        step();
        chk("t4_err_sticky", err_o, 1);

        // Reset with three outstanding and two queued.
        apu_gnt_i = 1'b1;
        data_req_i = 1'b1;
        data_ID_i = 9'h040;
        step();
        data_ID_i = 9'h080;
        step();
        data_ID_i = 9'h004;
        step();
        data_req_i = 1'b0;
        step();
        apu_gnt_i = 1'b0;
        data_req_i = 1'b1;
        data_ID_i = 9'h001;
        step();
        data_ID_i = 9'h002;
        step();
        data_req_i = 1'b0;
        #1;
        chk("t5_pre_req", apu_req_o, 1);
        chk("t5_pre_gnt", data_gnt_o, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_req", apu_req_o, 0);
        chk("t5_gnt", data_gnt_o, 1);
        chk("t5_err_clr", err_o, 0);
        apu_gnt_i = 1'b1;
        data_req_i = 1'b1;
        data_ID_i = 9'h008;
        step();
        data_req_i = 1'b0;
        #1;
        chk("t5_new_req", apu_req_o, 1);
        step();
        apu_rvalid_i = 1'b1;
        apu_result_i = 32'h4049_0FDB;
        step();
        apu_rvalid_i = 1'b0;
        #1;
        chk("t5_new_rvalid", data_r_valid_o, 9'h008);
        chk("t5_new_rdata", data_r_data_o, 32'h4049_0FDB);
        chk("t5_new_err", err_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
